// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader that fills the CPU instruction bus and holds the CPU in reset until a checksum-verified program arrives.
module prog_loader #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  output logic                      byte_ready,
  output logic [32*MEM_WORDS-1:0]   instruction_stream,
  output logic                      cpu_rst,
  output logic                      load_done,
  output logic                      load_err,
  output logic [15:0]               words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, RUN, ERR} state_t;
  localparam logic [15:0] MAXW = 16'(MEM_WORDS);
  state_t                   state_q;
  logic [32*MEM_WORDS-1:0]  stream_q;
  logic [7:0]               len_hi_q, csum_q;
  logic [15:0]              len_q, words_q;
  logic [23:0]              asm_q;
  logic [1:0]               bcnt_q;
  logic                     cpu_rst_q, load_done_q, load_err_q;
  logic                     fire;
  logic [15:0]              len_w;
  assign byte_ready         = state_q != RUN;
  assign fire               = byte_valid && byte_ready;
  assign len_w              = {len_hi_q, byte_data};
  assign instruction_stream = stream_q;
  assign cpu_rst            = cpu_rst_q;
  assign load_done          = load_done_q;
  assign load_err           = load_err_q;
  assign words_loaded       = words_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      stream_q    <= '0;
      len_hi_q    <= '0;
      csum_q      <= '0;
      len_q       <= '0;
      words_q     <= '0;
      asm_q       <= '0;
      bcnt_q      <= '0;
      cpu_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else if (fire) begin
      case (state_q)
        IDLE, ERR: if (byte_data == SYNC) begin
          state_q    <= LEN_HI;
          stream_q   <= '0;
          words_q    <= '0;
          csum_q     <= '0;
          bcnt_q     <= '0;
          load_err_q <= 1'b0;
        end
        LEN_HI: begin
          len_hi_q <= byte_data;
          state_q  <= LEN_LO;
        end
        LEN_LO: begin
          len_q      <= len_w;
          state_q    <= len_w > MAXW ? ERR : len_w == 16'd0 ? CSUM : DATA;
          load_err_q <= len_w > MAXW;
        end
        DATA: begin
          asm_q  <= {asm_q[15:0], byte_data};
          csum_q <= csum_q ^ byte_data;
          bcnt_q <= bcnt_q + 2'd1;
          // Fourth byte completes a word; bytes arrive MSB first.
          if (bcnt_q == 2'd3) begin
            stream_q[32*words_q +: 32] <= {asm_q, byte_data};
            words_q <= words_q + 16'd1;
            if (words_q + 16'd1 == len_q) state_q <= CSUM;
          end
        end
        CSUM: begin
          state_q     <= byte_data == csum_q ? RUN : ERR;
          cpu_rst_q   <= byte_data != csum_q;
          load_done_q <= byte_data == csum_q;
          load_err_q  <= byte_data != csum_q;
        end
        default: ;
      endcase
    end
  end
endmodule
